// File: rtl/video_dram_arb_pkg.sv
// Shared encodings for the video DRAM slot arbiter.
// Imported by the arbiter top and its fetch-pattern helper.
package video_dram_arb_pkg;

    localparam logic [1:0] VMODE_NONE  = 2'b00;
    localparam logic [1:0] VMODE_HALFQ = 2'b01;
    localparam logic [1:0] VMODE_HALF  = 2'b10;
    localparam logic [1:0] VMODE_FULL  = 2'b11;

    localparam int RFSH_W = 3;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_VID  = 2'b01,
        OWN_RFSH = 2'b10,
        OWN_CPU  = 2'b11
    } slot_owner_t;

endpackage

// File: rtl/video_dram_arb_slot_pattern.sv
// Video slot eligibility within an 8-slot bundle, per fetch density mode.
// Kept separate so new fetch patterns only touch this file.
module video_slot_pattern
    import video_dram_arb_pkg::*;
(
    input  logic [1:0] vmode,
    input  logic [2:0] phase,
    output logic       elig
);

    always_comb begin
        elig = 1'b0;
        case (vmode)
            VMODE_NONE:  elig = 1'b0;
            VMODE_HALFQ: elig = (phase[1:0] == 2'b00);
            VMODE_HALF:  elig = ~phase[0];
            VMODE_FULL:  elig = 1'b1;
            default:     elig = 1'b0;
        endcase
    end

endmodule

// File: rtl/video_dram_arb.sv
// Per-slot DRAM arbiter: video fetch window, refresh backlog and CPU
// share each cend slot, with exactly one registered owner per slot.
module video_dram_arb
    import video_dram_arb_pkg::*;
#(
    parameter int RFSH_MAX    = 4,
    parameter int RFSH_URGENT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cend,
    input  logic              pre_cend,
    input  logic              fetch_start,
    input  logic              fetch_end,
    input  logic [1:0]        vmode,
    input  logic              rfsh_req,
    input  logic              cpu_req,
    output logic              go,
    output logic              slot_video,
    output logic              slot_rfsh,
    output logic              slot_cpu,
    output logic [7:0]        vfetch_cnt,
    output logic [RFSH_W-1:0] rfsh_pend
);

    localparam logic [RFSH_W-1:0] PEND_MAX = RFSH_W'(RFSH_MAX);
    localparam logic [RFSH_W-1:0] PEND_URG = RFSH_W'(RFSH_URGENT);

    logic              go_q, go_d;
    logic [2:0]        phase_q, phase_d;
    logic [RFSH_W-1:0] pend_q, pend_d;
    logic [7:0]        vcnt_q, vcnt_d;
    logic              vid_q, vid_d;
    logic              rfsh_q, rfsh_d;
    logic              cpu_q, cpu_d;
    logic              elig;
    logic              vid_ok;
    slot_owner_t       owner;

    video_slot_pattern u_pattern (
        .vmode (vmode),
        .phase (phase_q),
        .elig  (elig)
    );

    assign vid_ok = go_q & elig;

    always_comb begin
        owner = OWN_IDLE;
        if (vid_ok)
            owner = OWN_VID;
        else if (pend_q >= PEND_URG)
            owner = OWN_RFSH;
        else if (cpu_req)
            owner = OWN_CPU;
        else if (pend_q != '0)
            owner = OWN_RFSH;
    end

    always_comb begin
        go_d    = go_q;
        phase_d = phase_q;
        if (cend) begin
            if (fetch_start) begin
                go_d    = 1'b1;
                phase_d = 3'd0;
            end else begin
                if (go_q)
                    phase_d = phase_q + 3'd1;
                if (fetch_end)
                    go_d = 1'b0;
            end
        end
    end

    always_comb begin
        vid_d  = vid_q;
        rfsh_d = rfsh_q;
        cpu_d  = cpu_q;
        if (pre_cend) begin
            vid_d  = (owner == OWN_VID);
            rfsh_d = (owner == OWN_RFSH);
            cpu_d  = (owner == OWN_CPU);
        end
    end

    // A grant and a new request in the same clk cancel out.
    always_comb begin
        pend_d = pend_q;
        if (pre_cend && owner == OWN_RFSH) begin
            if (!rfsh_req)
                pend_d = pend_q - RFSH_W'(1);
        end else if (rfsh_req && pend_q < PEND_MAX) begin
            pend_d = pend_q + RFSH_W'(1);
        end
    end

    always_comb begin
        vcnt_d = vcnt_q;
        if (cend && fetch_start)
            vcnt_d = 8'd0;
        else if (pre_cend && owner == OWN_VID && vcnt_q != 8'hFF)
            vcnt_d = vcnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q    <= 1'b0;
            phase_q <= 3'd0;
            pend_q  <= '0;
            vcnt_q  <= 8'd0;
            vid_q   <= 1'b0;
            rfsh_q  <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            go_q    <= go_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            vcnt_q  <= vcnt_d;
            vid_q   <= vid_d;
            rfsh_q  <= rfsh_d;
            cpu_q   <= cpu_d;
        end
    end

    assign go         = go_q;
    assign slot_video = vid_q;
    assign slot_rfsh  = rfsh_q;
    assign slot_cpu   = cpu_q;
    assign vfetch_cnt = vcnt_q;
    assign rfsh_pend  = pend_q;

endmodule
